mix_card_reader: RTL and testbench

//  Input-side counterpart of the OUT printer path: receives ASCII bytes on a UART line, converts

---
 rtl/mix_card_reader_if.sv | 10 +
 rtl/mix_card_reader.sv | 253 +++++++++++++++++++++++++
 tb/tb_mix_card_reader.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mix_card_reader_if.sv
// Memory store port of the MIX card reader: a word request held until the CPU grants a store.
interface mix_card_reader_if;
    logic        request;
    logic        store;
    logic [11:0] addressout;
    logic [29:0] out;

    modport master (output request, output addressout, output out, input store);
    modport slave  (input request, input addressout, input out, output store);
endinterface

// File: rtl/mix_card_reader.sv
// MIX card reader: UART 8N1 receiver, ASCII to MIX code conversion, 5-char word packing and
// a block writer that stores one BLOCK_WORDS card image through the request/store port.
module mix_card_reader #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned BLOCK_WORDS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              start,
    input  logic [11:0]       addressin,
    output logic              stop,
    output logic              busy,
    mix_card_reader_if.master mem,
    output logic              frame_err,
    output logic              overrun_err
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned WW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    typedef enum logic [1:0] {UIdle, UStart, UData, UStop} uart_e;
    typedef enum logic [1:0] {StIdle, StArmed, StFill} state_e;

    // Returns {is_char, is_lf, code}; CR yields neither flag so it is dropped.
    function automatic logic [7:0] decode(input logic [7:0] b);
        logic [7:0] u;
        logic [5:0] t;
        u = (b >= 8'h61 && b <= 8'h7a) ? b - 8'h20 : b;
        t = 6'd0;
        case (u) inside
            8'h0a:         return 8'h40;
            8'h0d:         return 8'h00;
            [8'h41:8'h49]: t = 6'(u - 8'h40);
            [8'h4a:8'h52]: t = 6'(u - 8'h3f);
            [8'h53:8'h5a]: t = 6'(u - 8'h3d);
            [8'h30:8'h39]: t = 6'(u - 8'h12);
            8'h2e: t = 6'd40;
            8'h2c: t = 6'd41;
            8'h28: t = 6'd42;
            8'h29: t = 6'd43;
            8'h2b: t = 6'd44;
            8'h2d: t = 6'd45;
            8'h2a: t = 6'd46;
            8'h2f: t = 6'd47;
            8'h3d: t = 6'd48;
            8'h24: t = 6'd49;
            8'h3c: t = 6'd50;
            8'h3e: t = 6'd51;
            8'h40: t = 6'd52;
            8'h3b: t = 6'd53;
            8'h3a: t = 6'd54;
            8'h27: t = 6'd55;
            default: t = 6'd0;
        endcase
        return {2'b10, t};
    endfunction

    logic          sync1_q, sync2_q, prev_q;
    uart_e         uart_q, uart_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          byte_vld, frame_set;

    always_comb begin
        uart_d    = uart_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        byte_vld  = 1'b0;
        frame_set = 1'b0;
        case (uart_q)
            UIdle: if (prev_q && !sync2_q) begin
                uart_d = UStart;
                cnt_d  = '0;
            end
            UStart: if (cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
                cnt_d  = '0;
                bit_d  = 3'd0;
                uart_d = sync2_q ? UIdle : UData;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            UData: if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                cnt_d = '0;
                sh_d  = {sync2_q, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) uart_d = UStop;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            UStop: if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                cnt_d  = '0;
                uart_d = UIdle;
                if (sync2_q) byte_vld = 1'b1;
                else         frame_set = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            default: uart_d = UIdle;
        endcase
    end

    logic [7:0] dec;
    logic       rx_char, rx_lf;
    assign dec     = decode(sh_q);
    assign rx_char = byte_vld & dec[7];
    assign rx_lf   = byte_vld & dec[6];

    state_e          state_q, state_d;
    logic [11:0]     base_q, base_d, addr_q, addr_d;
    logic [WW-1:0]   w_q, w_d;
    logic [2:0]      c_q, c_d;
    logic [29:0]     pack_q, pack_d, out_q, out_d, flush_word;
    logic            req_q, req_d, stop_q, stop_d, ferr_q, ferr_d, oerr_q, oerr_d;
    logic            granted, last_done;

    assign granted   = req_q & mem.store;
    assign last_done = granted && (w_q == WW'(BLOCK_WORDS - 1));

    // Partial word on LF: received chars left-justified, space (0) padding on the right.
    always_comb begin
        flush_word = pack_q;
        case (c_q)
            3'd1:    flush_word = {pack_q[5:0], 24'd0};
            3'd2:    flush_word = {pack_q[11:0], 18'd0};
            3'd3:    flush_word = {pack_q[17:0], 12'd0};
            3'd4:    flush_word = {pack_q[23:0], 6'd0};
            default: flush_word = pack_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        addr_d  = addr_q;
        w_d     = w_q;
        c_d     = c_q;
        pack_d  = pack_q;
        out_d   = out_q;
        req_d   = req_q;
        stop_d  = 1'b0;
        ferr_d  = ferr_q | frame_set;
        oerr_d  = oerr_q;
        if (granted) begin
            req_d = 1'b0;
            w_d   = w_q + WW'(1);
        end
        case (state_q)
            StIdle: if (start) begin
                state_d = StArmed;
                stop_d  = 1'b1;
                base_d  = addressin;
                w_d     = '0;
                c_d     = 3'd0;
                pack_d  = '0;
            end
            StArmed: begin
                if (last_done) begin
                    state_d = StIdle;
                end else if (rx_char) begin
                    if (c_q == 3'd4) begin
                        pack_d = '0;
                        c_d    = 3'd0;
                        if (req_q) begin
                            oerr_d = 1'b1;
                        end else begin
                            req_d  = 1'b1;
                            out_d  = {pack_q[23:0], dec[5:0]};
                            addr_d = base_q + 12'(w_q);
                        end
                    end else begin
                        pack_d = {pack_q[23:0], dec[5:0]};
                        c_d    = c_q + 3'd1;
                    end
                end else if (rx_lf) begin
                    state_d = StFill;
                    pack_d  = '0;
                    c_d     = 3'd0;
                    if (c_q != 3'd0) begin
                        if (req_q) begin
                            oerr_d = 1'b1;
                        end else begin
                            req_d  = 1'b1;
                            out_d  = flush_word;
                            addr_d = base_q + 12'(w_q);
                        end
                    end
                end
            end
            StFill: begin
                if (last_done) begin
                    state_d = StIdle;
                end else if (!req_q) begin
                    req_d  = 1'b1;
                    out_d  = '0;
                    addr_d = base_q + 12'(w_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            uart_q  <= UIdle;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            sh_q    <= 8'd0;
            state_q <= StIdle;
            base_q  <= 12'd0;
            addr_q  <= 12'd0;
            w_q     <= '0;
            c_q     <= 3'd0;
            pack_q  <= '0;
            out_q   <= '0;
            req_q   <= 1'b0;
            stop_q  <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            uart_q  <= uart_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            w_q     <= w_d;
            c_q     <= c_d;
            pack_q  <= pack_d;
            out_q   <= out_d;
            req_q   <= req_d;
            stop_q  <= stop_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    assign stop           = stop_q;
    assign busy           = (state_q != StIdle);
    assign mem.request    = req_q;
    assign mem.addressout = addr_q;
    assign mem.out        = out_q;
    assign frame_err      = ferr_q;
    assign overrun_err    = oerr_q;
endmodule

// File: tb/tb_mix_card_reader.sv
// Self-checking bench for mix_card_reader: directed card images plus random lines, checked
// against a card-image model and a per-cycle busy/stop model.
module tb_mix_card_reader;
    localparam int CPB = 16;
    localparam int BW  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic        start = 1'b0;
    logic [11:0] addressin = 12'd0;
    logic        stop, busy, frame_err, overrun_err;

    mix_card_reader_if bus();

    mix_card_reader #(.CLKS_PER_BIT(CPB), .BLOCK_WORDS(BW)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .start       (start),
        .addressin   (addressin),
        .stop        (stop),
        .busy        (busy),
        .mem         (bus),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stores, in order.
    logic [11:0] q_addr[$];
    logic [29:0] q_data[$];
    bit          q_last[$];

    bit grant_en = 1'b1;
    int grant_dly = 1;
    int wait_cnt = 0;
    bit m_busy = 1'b0;
    bit m_stop = 1'b0;
    bit this_last;

    task automatic push_exp(input int addr, input logic [29:0] data, input bit last);
        q_addr.push_back(12'(addr));
        q_data.push_back(data);
        q_last.push_back(last);
    endtask

    function automatic logic [29:0] word5(input int a, input int b, input int c, input int d,
                                          input int e);
        return {6'(a), 6'(b), 6'(c), 6'(d), 6'(e)};
    endfunction

    // MIX code = position of the character in this table; '#' marks unused codes.
    function automatic int mix_code(input byte b);
        string tbl;
        byte   u;
        tbl = " ABCDEFGHI#JKLMNOPQR##STUVWXYZ0123456789.,()+-*/=$<>@;:'";
        u = (b >= 8'h61 && b <= 8'h7a) ? byte'(b - 8'h20) : b;
        if (u == 8'h23) return 0;
        for (int i = 0; i < tbl.len(); i++)
            if (tbl[i] == u) return i;
        return 0;
    endfunction

    // A card is 5*BW characters: the line up to LF (CR skipped), padded with spaces.
    task automatic expect_card(input int base, input string s);
        int codes[$];
        logic [29:0] wd;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0d) continue;
            if (s[i] == 8'h0a) break;
            codes.push_back(mix_code(s[i]));
            if (codes.size() == 5 * BW) break;
        end
        for (int w = 0; w < BW; w++) begin
            wd = '0;
            for (int k = 0; k < 5; k++) begin
                wd = wd << 6;
                if (5 * w + k < codes.size()) wd = wd | 30'(codes[5 * w + k]);
            end
            push_exp((base + w) % 4096, wd, w == BW - 1);
        end
    endtask

    // Grant driver and per-cycle checker; sampled on the falling edge.
    always @(negedge clk) begin
        this_last = 1'b0;
        if (!reset) begin
            m_busy = 1'b0;
            m_stop = 1'b0;
            bus.store = 1'b0;
            wait_cnt = 0;
        end else begin
            check("busy", busy, m_busy);
            check("stop", stop, m_stop);
            if (bus.store) begin
                bus.store = 1'b0;
            end else if (grant_en && bus.request) begin
                if (wait_cnt < grant_dly) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    checks++;
                    if (q_addr.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_request: got addr %0h data %0h expected none",
                                 bus.addressout, bus.out);
                    end else begin
                        check("store_addr", bus.addressout, q_addr[0]);
                        check("store_data", bus.out, q_data[0]);
                        this_last = q_last[0];
                        void'(q_addr.pop_front());
                        void'(q_data.pop_front());
                        void'(q_last.pop_front());
                    end
                    bus.store = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end
            m_stop = start && !m_busy;
            if (start && !m_busy)          m_busy = 1'b1;
            else if (bus.store && this_last) m_busy = 1'b0;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        q_addr.delete();
        q_data.delete();
        q_last.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic cmd_in(input int m);
        @(posedge clk);
        #1 addressin = 12'(m);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic hold(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(posedge clk);
        #1 hold(1'b0);
        for (int i = 0; i < 8; i++) hold(b[i]);
        hold(stop_ok);
        if (!stop_ok) hold(1'b1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (!busy && q_addr.size() == 0) done = 1'b1;
        end
        check(name, done, 1);
    endtask

    initial begin
        string s;
        int    base;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_stop", stop, 0);
        check("rst_busy", busy, 0);
        check("rst_request", bus.request, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun_err", overrun_err, 0);
        reset = 1'b1;

        // HELLO then LF: one word, rest of card is spaces
        push_exp(100, word5(8, 5, 13, 13, 16), 1'b0);
        for (int w = 1; w < BW; w++) push_exp(100 + w, 30'd0, w == BW - 1);
        cmd_in(100);
        send_str("HELLO\n");
        wait_done("hello_block");

        // Full 80-char card with no LF, then a line arriving in idle
        for (int w = 0; w < BW; w++) push_exp(200 + w, word5(39, 39, 39, 39, 39), w == BW - 1);
        cmd_in(200);
        for (int i = 0; i < 5 * BW; i++) send_byte(8'h39, 1'b1);
        wait_done("full_block");
        send_str("A\n");
        repeat (40) @(negedge clk);
        check("idle_no_request", bus.request, 0);
        check("idle_no_busy", busy, 0);

        // Framing error drops the byte; following chars pack normally
        do_reset();
        cmd_in(300);
        send_byte(8'h41, 1'b0);
        check("frame_err_set", frame_err, 1);
        push_exp(300, word5(1, 2, 3, 4, 5), 1'b0);
        for (int w = 1; w < BW; w++) push_exp(300 + w, 30'd0, w == BW - 1);
        send_str("ABCDE\n");
        wait_done("after_frame_err");
        check("frame_err_sticky", frame_err, 1);

        // Overrun: second word completes while the first is still pending
        do_reset();
        check("frame_err_cleared", frame_err, 0);
        grant_en = 1'b0;
        cmd_in(400);
        send_str("ABCDEFGHIJ");
        repeat (5) @(negedge clk);
        check("ovr_request", bus.request, 1);
        check("ovr_out_kept", bus.out, word5(1, 2, 3, 4, 5));
        check("ovr_addr", bus.addressout, 400);
        check("ovr_flag", overrun_err, 1);
        push_exp(400, word5(1, 2, 3, 4, 5), 1'b0);
        for (int w = 1; w < BW; w++) push_exp(400 + w, 30'd0, w == BW - 1);
        grant_en = 1'b1;
        send_str("\n");
        wait_done("overrun_block");

        // Reset in the middle of a block, then restart from word 0
        do_reset();
        grant_en = 1'b0;
        cmd_in(500);
        send_str("ABCDEFG");
        repeat (5) @(negedge clk);
        check("mid_request_high", bus.request, 1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_request", bus.request, 0);
        check("mid_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        grant_en = 1'b1;
        push_exp(500, word5(27, 28, 0, 0, 0), 1'b0);
        for (int w = 1; w < BW; w++) push_exp(500 + w, 30'd0, w == BW - 1);
        cmd_in(500);
        send_str("XY\n");
        wait_done("restart_block");

        // Random lines; a second IN while busy must be ignored
        for (int r = 0; r < 6; r++) begin
            grant_dly = $urandom_range(0, 4);
            base = (r == 0) ? 4090 : $urandom_range(0, 4095);
            s = "";
            for (int i = $urandom_range(0, 18); i > 0; i--) begin
                if ($urandom_range(0, 9) == 0) s = {s, "\r"};
                else s = {s, string'(byte'($urandom_range(32, 126)))};
            end
            s = {s, "\n"};
            expect_card(base, s);
            cmd_in(base);
            cmd_in(12'habc);
            send_str(s);
            wait_done("random_block");
        end

        check("queue_drained", q_addr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
